// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit framer.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_DRAIN    = 3'd4
    } state_t;

    localparam int DATA_BITS       = 8;
    localparam int TICKS_PER_FRAME = DATA_BITS + 1;
    localparam int ARM_RETRY       = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue for the framer: push lands on the next edge, head is visible combinationally.
// A push when full is dropped (flagged on drop) unless a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// 8N1 transmitter: queues bytes, arms the baud generator per byte, shifts LSB first on bud_clk.
// tx falls 2 cycles after a push into an idle framer; pushes into a full queue are dropped and flagged.
module uart_tx_framer #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       bud_clk,
    input  logic       baud_status,
    input  logic       clr_overflow,
    output logic       baud_trigger,
    output logic       baud_enable,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       fifo_full,
    output logic       overflow
);

    import uart_pkg::*;

    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [3:0]           bit_cnt;
    logic [1:0]           wait_cnt;
    logic [7:0]           head;
    logic                 empty;
    logic                 drop;
    logic                 pop;

    assign pop = (state == ST_IDLE) && !empty && !baud_status;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (wr_en),
        .din    (wr_data),
        .pop    (pop),
        .dout   (head),
        .full   (fifo_full),
        .empty  (empty),
        .drop   (drop)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Outputs are registered on the transition into a state, so each state's
    // outputs are valid for the whole cycle it occupies.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            tx           <= 1'b1;
            baud_trigger <= 1'b0;
            baud_enable  <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            shift_reg    <= '1;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
        end else begin
            baud_trigger <= 1'b0;
            baud_enable  <= 1'b0;
            tx_done      <= 1'b0;
            tx_busy      <= (state != ST_IDLE) || !empty;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift_reg    <= head;
                        bit_cnt      <= '0;
                        tx           <= 1'b0;
                        baud_trigger <= 1'b1;
                        baud_enable  <= 1'b1;
                        state        <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    tx       <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    tx <= 1'b0;
                    if (baud_status) begin
                        state <= ST_SHIFT;
                    end else if (wait_cnt == 2'(ARM_RETRY - 1)) begin
                        baud_trigger <= 1'b1;
                        baud_enable  <= 1'b1;
                        state        <= ST_ARM;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_SHIFT: begin
                    // A generator abort drops the byte and abandons the frame.
                    if (!baud_status) begin
                        tx    <= 1'b1;
                        state <= ST_IDLE;
                    end else if (bud_clk) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'(TICKS_PER_FRAME - 1)) begin
                            tx    <= 1'b1;
                            state <= ST_DRAIN;
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= {1'b1, shift_reg[DATA_BITS-1:1]};
                        end
                    end
                end
                ST_DRAIN: begin
                    tx <= 1'b1;
                    if (!baud_status) begin
                        tx_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer with a behavioural baud generator and a tx-line monitor.
module tb_uart_tx_framer;

    localparam int BIT  = 12;
    localparam int TAIL = 3;

    logic       sysclk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       bud_clk;
    logic       gen_status;
    logic       hold_busy;
    logic       baud_status;
    logic       clr_overflow;
    logic       baud_trigger;
    logic       baud_enable;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic       fifo_full;
    logic       overflow;

    int         total;
    int         bad;
    int         cyc;
    int         nbits;
    int         done_cnt;
    int         exp_frames;
    int         ignore_cnt;
    int         abort_at;
    int         prev_trig;
    int         last_trig;
    logic       armed;
    logic       tick_pend;
    logic       frame_pending;
    logic       gen_active;
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    logic [7:0] sb [$];

    assign baud_status = gen_status | hold_busy;

    uart_tx_framer #(
        .FIFO_DEPTH (4),
        .DATA_BITS  (8)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .bud_clk      (bud_clk),
        .baud_status  (baud_status),
        .clr_overflow (clr_overflow),
        .baud_trigger (baud_trigger),
        .baud_enable  (baud_enable),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Generator model: status rises one cycle after the trigger, 9 ticks BIT+1 cycles apart.
    task automatic run_frame();
        gen_active = 1'b1;
        @(posedge sysclk); #1;
        gen_status = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            repeat (BIT) @(posedge sysclk);
            #1 bud_clk = 1'b1;
            @(posedge sysclk); #1;
            bud_clk = 1'b0;
            if (t == abort_at) begin
                gen_status = 1'b0;
                abort_at   = 0;
                @(posedge sysclk);
                @(negedge sysclk);
                check("abort_tx_high", tx, 1);
                gen_active = 1'b0;
                return;
            end
        end
        repeat (TAIL) @(posedge sysclk);
        #1 gen_status = 1'b0;
        gen_active = 1'b0;
    endtask

    initial begin
        gen_status = 1'b0;
        bud_clk    = 1'b0;
        gen_active = 1'b0;
        forever begin
            @(posedge sysclk); #1;
            if (baud_trigger && !reset) begin
                if (ignore_cnt > 0) ignore_cnt--;
                else run_frame();
            end
        end
    end

    // Monitor: samples tx after each tick the DUT consumed and pops the scoreboard per frame.
    initial begin
        armed = 0; tick_pend = 0; frame_pending = 0; nbits = 0;
        done_cnt = 0; cyc = 0; prev_trig = 0; last_trig = 0; rx_byte = 0;
        forever begin
            @(negedge sysclk);
            cyc++;
            if (reset) begin
                armed = 0; tick_pend = 0; nbits = 0; frame_pending = 0;
            end else begin
                if (tick_pend) begin
                    nbits++;
                    if (nbits <= 8) begin
                        rx_byte[nbits-1] = tx;
                    end else begin
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL frame_unexpected: got %0h, want no frame", rx_byte);
                        end else begin
                            exp_byte = sb.pop_front();
                            check("frame_byte", rx_byte, exp_byte);
                            check("stop_bit", tx, 1);
                        end
                        frame_pending = 1;
                        armed = 0;
                    end
                end
                if (baud_trigger) begin
                    check("start_bit", tx, 0);
                    armed = 1;
                    nbits = 0;
                    prev_trig = last_trig;
                    last_trig = cyc;
                end
                if (tx_done) begin
                    check("done_after_frame", frame_pending, 1);
                    frame_pending = 0;
                    done_cnt++;
                end
                tick_pend = bud_clk && armed;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        @(posedge sysclk); #1;
        wr_en = 1'b1;
        wr_data = b;
        @(posedge sysclk); #1;
        wr_en = 1'b0;
        if (expect_tx) begin
            sb.push_back(b);
            exp_frames++;
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        repeat (4) @(negedge sysclk);
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk);
            if (!tx_busy && !gen_active && !baud_status) begin
                ok = 1;
                break;
            end
        end
        check("idle_reached", ok, 1);
    endtask

    task automatic pulse_inputs(input logic w, input logic [7:0] d, input logic c);
        @(posedge sysclk); #1;
        wr_en = w;
        wr_data = d;
        clr_overflow = c;
        @(posedge sysclk); #1;
        wr_en = 1'b0;
        clr_overflow = 1'b0;
        @(negedge sysclk);
    endtask

    initial begin
        logic [7:0] burst [4];
        bit         reached;
        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h0F;
        total = 0; bad = 0; exp_frames = 0; ignore_cnt = 0; abort_at = 0;
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0; hold_busy = 1'b0;

        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check("rst_tx", tx, 1);
        check("rst_trigger", baud_trigger, 0);
        check("rst_enable", baud_enable, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_full", fifo_full, 0);
        check("rst_overflow", overflow, 0);

        // Single byte, with push-to-start-bit latency.
        @(posedge sysclk); #1;
        reset = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        sb.push_back(8'hA5);
        exp_frames++;
        @(posedge sysclk); #1;
        wr_en = 1'b0;
        @(negedge sysclk);
        check("lat_pre_start", tx, 1);
        @(negedge sysclk);
        check("lat_start", tx, 0);
        wait_idle(400);
        check("single_busy_after", tx_busy, 0);
        check("single_done_cnt", done_cnt, 1);

        // Burst into a stalled framer, then overflow handling.
        @(posedge sysclk); #1;
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge sysclk); #1;
            wr_en = 1'b1;
            wr_data = burst[i];
            sb.push_back(burst[i]);
            exp_frames++;
        end
        @(posedge sysclk); #1;
        wr_en = 1'b0;
        @(negedge sysclk);
        check("burst_full", fifo_full, 1);
        check("burst_no_overflow", overflow, 0);
        check("burst_busy", tx_busy, 1);
        pulse_inputs(1'b1, 8'hEE, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_still_full", fifo_full, 1);
        pulse_inputs(1'b0, 8'h00, 1'b1);
        check("ovf_clr", overflow, 0);
        pulse_inputs(1'b1, 8'hDD, 1'b1);
        check("ovf_set_wins", overflow, 1);
        pulse_inputs(1'b0, 8'h00, 1'b1);
        check("ovf_clr2", overflow, 0);
        @(posedge sysclk); #1;
        hold_busy = 1'b0;
        wait_idle(1500);
        check("burst_done_cnt", done_cnt, 5);

        // Generator ignores the first arm request.
        ignore_cnt = 1;
        push_byte(8'hC3, 1);
        wait_idle(600);
        check("retry_gap", last_trig - prev_trig, 5);
        check("retry_done_cnt", done_cnt, 6);

        // Generator abort after tick 3; the queued byte behind it must still go out.
        abort_at = 3;
        push_byte(8'h5A, 0);
        push_byte(8'h96, 1);
        wait_idle(800);
        check("abort_done_cnt", done_cnt, 7);

        // Reset during bit 4 with a second byte queued.
        push_byte(8'h77, 0);
        push_byte(8'h11, 0);
        reached = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sysclk);
            if (armed && nbits >= 4) begin
                reached = 1;
                break;
            end
        end
        check("reached_bit4", reached, 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_full", fifo_full, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_trigger", baud_trigger, 0);
        check("midrst_done", tx_done, 0);
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        wait_idle(600);
        push_byte(8'h3C, 1);
        wait_idle(400);
        check("final_done_cnt", done_cnt, 8);

        check("sb_drained", sb.size(), 0);
        check("frames_total", done_cnt, exp_frames);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
